// File: rtl/cabac_renorm_refill.sv
// cabac_renorm_refill: the state-holding feedback stage of the CABAC regular-bin decoder.
// It keeps range, value and bits_needed, and registers each bin step from the bin decoder.
// When renormalisation has used up the buffered bits, it pulls in one bitstream byte.
// It also runs the slice-start init, which loads the range and then two bytes of value.
// Every output comes straight from a register.
module cabac_renorm_refill #(
    parameter logic        [8:0] INIT_RANGE     = 9'd510,
    parameter logic signed [4:0] INIT_BITS_NEED = 5'sb11000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    input  logic        i_bin_valid,
    output logic        o_bin_ready,
    input  logic [8:0]  i_range_in,
    input  logic [15:0] i_value_in,
    input  logic [2:0]  i_num_bits,
    input  logic        i_renorm,
    output logic [8:0]  o_dec_range,
    output logic [15:0] o_dec_value,
    output logic        o_dec_valid,
    output logic [31:0] o_bytes_used
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_HI,
        S_INIT_LO,
        S_READY,
        S_REFILL
    } state_t;

    state_t             r_state;
    logic        [8:0]  r_range;
    logic        [15:0] r_value;
    logic signed [4:0]  r_bits_needed;
    logic        [31:0] r_bytes_used;
    logic               r_byte_ready;
    logic               r_bin_ready;
    logic               r_dec_valid;

    logic signed [4:0]  w_bn_next;
    logic        [15:0] w_refill_value;
    logic               w_byte_hs;
    logic               w_bin_hs;

    // Bits-needed update for a renorm step, and the value after merging a refill byte.
    // In REFILL, bits_needed lies in 0..6, so its low three bits give the shift amount.
    always_comb begin
        w_bn_next      = r_bits_needed + signed'({2'b00, i_num_bits});
        w_refill_value = r_value + (16'(i_byte_data) << r_bits_needed[2:0]);
        w_byte_hs      = i_byte_valid & r_byte_ready;
        w_bin_hs       = i_bin_valid & r_bin_ready;
    end

    // Decoder state machine. Outputs are registered along with each state change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_range       <= '0;
            r_value       <= '0;
            r_bits_needed <= '0;
            r_bytes_used  <= '0;
            r_byte_ready  <= 1'b0;
            r_bin_ready   <= 1'b0;
            r_dec_valid   <= 1'b0;
        end else if (i_start) begin
            r_state       <= S_INIT_HI;
            r_range       <= INIT_RANGE;
            r_value       <= '0;
            r_bits_needed <= INIT_BITS_NEED;
            r_bytes_used  <= '0;
            r_byte_ready  <= 1'b1;
            r_bin_ready   <= 1'b0;
            r_dec_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_byte_ready <= 1'b0;
                    r_bin_ready  <= 1'b0;
                    r_dec_valid  <= 1'b0;
                end
                S_INIT_HI: begin
                    if (w_byte_hs) begin
                        r_value[15:8] <= i_byte_data;
                        r_bytes_used  <= r_bytes_used + 32'd1;
                        r_state       <= S_INIT_LO;
                    end
                end
                S_INIT_LO: begin
                    if (w_byte_hs) begin
                        r_value[7:0] <= i_byte_data;
                        r_bytes_used <= r_bytes_used + 32'd1;
                        r_state      <= S_READY;
                        r_byte_ready <= 1'b0;
                        r_bin_ready  <= 1'b1;
                        r_dec_valid  <= 1'b1;
                    end
                end
                S_READY: begin
                    if (w_bin_hs) begin
                        r_range <= i_range_in;
                        r_value <= i_value_in;
                        if (i_renorm) begin
                            r_bits_needed <= w_bn_next;
                            // A non-negative bits_needed means the buffered bits are exhausted.
                            if (!w_bn_next[4]) begin
                                r_state      <= S_REFILL;
                                r_byte_ready <= 1'b1;
                                r_bin_ready  <= 1'b0;
                                r_dec_valid  <= 1'b0;
                            end
                        end
                    end
                end
                S_REFILL: begin
                    if (w_byte_hs) begin
                        r_value       <= w_refill_value;
                        r_bits_needed <= r_bits_needed - 5'sd8;
                        r_bytes_used  <= r_bytes_used + 32'd1;
                        r_state       <= S_READY;
                        r_byte_ready  <= 1'b0;
                        r_bin_ready   <= 1'b1;
                        r_dec_valid   <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b0;
                    r_bin_ready  <= 1'b0;
                    r_dec_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_bin_ready  = r_bin_ready;
    assign o_dec_range  = r_range;
    assign o_dec_value  = r_value;
    assign o_dec_valid  = r_dec_valid;
    assign o_bytes_used = r_bytes_used;

endmodule

// File: tb/tb_cabac_renorm_refill.sv
// Directed testbench for cabac_renorm_refill. Expected values are worked out by hand.
module tb_cabac_renorm_refill;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        bin_valid;
    logic        bin_ready;
    logic [8:0]  range_in;
    logic [15:0] value_in;
    logic [2:0]  num_bits;
    logic        renorm;
    logic [8:0]  dec_range;
    logic [15:0] dec_value;
    logic        dec_valid;
    logic [31:0] bytes_used;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    cabac_renorm_refill #(
        .INIT_RANGE     (9'd510),
        .INIT_BITS_NEED (5'sb11000)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_byte_data  (byte_data),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .i_bin_valid  (bin_valid),
        .o_bin_ready  (bin_ready),
        .i_range_in   (range_in),
        .i_value_in   (value_in),
        .i_num_bits   (num_bits),
        .i_renorm     (renorm),
        .o_dec_range  (dec_range),
        .o_dec_value  (dec_value),
        .o_dec_valid  (dec_valid),
        .o_bytes_used (bytes_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic bready, input logic binr,
                               input logic dv);
        check({tag, ".byte_ready"}, 32'(byte_ready), 32'(bready));
        check({tag, ".bin_ready"},  32'(bin_ready),  32'(binr));
        check({tag, ".dec_valid"},  32'(dec_valid),  32'(dv));
    endtask

    // Presents one bin step for a single cycle.
    task automatic bin_step(input logic [8:0] r, input logic [15:0] v, input logic rn,
                            input logic [2:0] nb);
        bin_valid = 1'b1;
        range_in  = r;
        value_in  = v;
        renorm    = rn;
        num_bits  = nb;
        step();
        bin_valid = 1'b0;
    endtask

    // Presents one byte for a single cycle.
    task automatic give_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; byte_data = '0; byte_valid = 1'b0;
        bin_valid = 1'b0; range_in = '0; value_in = '0; num_bits = '0; renorm = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst.range", 32'(dec_range), 32'd0);
        check("rst.value", 32'(dec_value), 32'd0);
        check("rst.bytes", bytes_used, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // T1: init loads range 510 and value 0xA53C
        start = 1'b1;
        step();
        start = 1'b0;
        check_flags("t1.hi", 1'b1, 1'b0, 1'b0);
        check("t1.range", 32'(dec_range), 32'd510);
        give_byte(8'hA5);
        check("t1.bytes1", bytes_used, 32'd1);
        check_flags("t1.lo", 1'b1, 1'b0, 1'b0);
        give_byte(8'h3C);
        check("t1.value", 32'(dec_value), 32'h0000A53C);
        check("t1.range2", 32'(dec_range), 32'd510);
        check("t1.bytes2", bytes_used, 32'd2);
        check_flags("t1.ready", 1'b0, 1'b1, 1'b1);

        // T2: MPS without renorm; a stray byte in READY is ignored; num_bits ignored
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        bin_step(9'd400, 16'h1234, 1'b0, 3'd7);
        byte_valid = 1'b0;
        check("t2.range", 32'(dec_range), 32'd400);
        check("t2.value", 32'(dec_value), 32'h00001234);
        check("t2.bytes", bytes_used, 32'd2);
        check_flags("t2", 1'b0, 1'b1, 1'b1);

        // T3: bits_needed -8 +1 = -7, no refill
        bin_step(9'd300, 16'h2222, 1'b1, 3'd1);
        check("t3.range", 32'(dec_range), 32'd300);
        check_flags("t3", 1'b0, 1'b1, 1'b1);

        // -7 +5 = -2, still READY
        bin_step(9'd310, 16'h3333, 1'b1, 3'd5);
        check("t3b.value", 32'(dec_value), 32'h00003333);
        check_flags("t3b", 1'b0, 1'b1, 1'b1);

        // T4: -2 +3 = 1 -> REFILL
        bin_step(9'd320, 16'h4000, 1'b1, 3'd3);
        check("t4.range", 32'(dec_range), 32'd320);
        check_flags("t4.refill", 1'b1, 1'b0, 1'b0);

        // T5: stall for 5 cycles; a bin step offered meanwhile must not be taken
        bin_valid = 1'b1; range_in = 9'd99; value_in = 16'hDEAD; renorm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_flags("t5.stall", 1'b1, 1'b0, 1'b0);
            check("t5.range", 32'(dec_range), 32'd320);
            check("t5.bytes", bytes_used, 32'd2);
        end
        bin_valid = 1'b0;
        give_byte(8'hFF);
        check("t4.value", 32'(dec_value), 32'h000041FE);
        check("t4.bytes", bytes_used, 32'd3);
        check_flags("t4.done", 1'b0, 1'b1, 1'b1);

        // bits_needed now -7; +7 = 0 -> refill with no shift: 0x0100 + 0xAB
        bin_step(9'd330, 16'h0100, 1'b1, 3'd7);
        check_flags("bn0.refill", 1'b1, 1'b0, 1'b0);
        give_byte(8'hAB);
        check("bn0.value", 32'(dec_value), 32'h000001AB);
        check("bn0.bytes", bytes_used, 32'd4);

        // -8 +7 = -1 stays READY
        bin_step(9'd340, 16'hFFF0, 1'b1, 3'd7);
        check_flags("bnm1", 1'b0, 1'b1, 1'b1);
        // -1 +7 = 6 -> refill, 0xFFF0 + (0xFF<<6) = 0x13FB0 -> 0x3FB0
        bin_step(9'd350, 16'hFFF0, 1'b1, 3'd7);
        check_flags("bn6.refill", 1'b1, 1'b0, 1'b0);
        give_byte(8'hFF);
        check("bn6.value", 32'(dec_value), 32'h00003FB0);
        check("bn6.bytes", bytes_used, 32'd5);

        // start beats a simultaneous bin step
        start = 1'b1;
        bin_step(9'd100, 16'h5555, 1'b0, 3'd0);
        start = 1'b0;
        check("sw.range", 32'(dec_range), 32'd510);
        check("sw.bytes", bytes_used, 32'd0);
        check_flags("sw", 1'b1, 1'b0, 1'b0);

        // T6b: start during INIT_LO restarts at INIT_HI and clears bytes_used
        give_byte(8'hA0);
        check("t6b.bytes1", bytes_used, 32'd1);
        start = 1'b1;
        give_byte(8'h11);
        start = 1'b0;
        check("t6b.bytes0", bytes_used, 32'd0);
        check_flags("t6b.hi", 1'b1, 1'b0, 1'b0);
        give_byte(8'h12);
        give_byte(8'h34);
        check("t6b.value", 32'(dec_value), 32'h00001234);
        check("t6b.bytes2", bytes_used, 32'd2);
        check_flags("t6b.ready", 1'b0, 1'b1, 1'b1);

        // T6a: reset during REFILL (bits_needed -8 -> -1 -> 6)
        bin_step(9'd360, 16'h0001, 1'b1, 3'd7);
        bin_step(9'd370, 16'h0002, 1'b1, 3'd7);
        check_flags("t6a.refill", 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        give_byte(8'h55);
        rst = 1'b0;
        check("t6a.range", 32'(dec_range), 32'd0);
        check("t6a.value", 32'(dec_value), 32'd0);
        check("t6a.bytes", bytes_used, 32'd0);
        check_flags("t6a", 1'b0, 1'b0, 1'b0);

        // Bytes offered in IDLE are not consumed
        give_byte(8'h66);
        check("idle.bytes", bytes_used, 32'd0);
        check_flags("idle", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
